rs_stream_decoder: RTL and testbench
====================================

Name: rs_stream_decoder

Overview:
Parametrised, streaming single-symbol-error Reed-Solomon decoder over GF(2^SYMBOL_WIDTH). It accepts one codeword symbol per handshake, computes S1 = v(α) and S2 = v(α²) on the fly by Horner's rule, and buffers the codeword. It then solves X1 = S2/S1 and Y1 = S1²/S2 and streams the corrected codeword out with per-codeword status flags. It replaces the fixed-width, parallel-input RS_Decoder in the decode path.

Parameters:
SYMBOL_WIDTH, 3, bits per symbol m; field is GF(2^m)
N, 7, symbols per codeword; must satisfy 3 <= N <= 2^m-1
PRIM_POLY, 4'b1011, primitive polynomial, SYMBOL_WIDTH+1 bits (default x³+x+1); α = 2
LOC_WIDTH, $clog2(N), derived; width of the error-location index

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
in_valid  input  1  in_symbol valid
in_ready  output  1  decoder accepts an input symbol this cycle
in_symbol  input  SYMBOL_WIDTH  codeword symbol; first symbol is coefficient of degree N-1, last is degree 0
out_valid  output  1  out_symbol valid
out_ready  input  1  downstream accepts an output symbol
out_symbol  output  SYMBOL_WIDTH  corrected symbol, same order as input
out_last  output  1  high with the degree-0 output symbol
err_detected  output  1  S1 != 0 or S2 != 0; held for the whole output codeword
err_corrected  output  1  single error located and fixed
err_uncorrectable  output  1  error detected but not correctable; data passed unchanged
err_loc  output  LOC_WIDTH  degree j of the corrected symbol; 0 when err_corrected = 0

Behaviour:
- Reset asserted: state COLLECT; in_ready = 1. Outputs out_valid, out_last and all err_* = 0; out_symbol = 0. Symbol counter = 0; S1 and S2 accumulators = 0. Buffer contents are don't-care.
- States: COLLECT -> SOLVE -> OUTPUT -> COLLECT.
- COLLECT: in_ready = 1. On each in_valid && in_ready:
  - buf[cnt] <= in_symbol
  - S1 <= S1·α ^ in_symbol
  - S2 <= S2·α² ^ in_symbol
  - cnt++
  - On acceptance of the Nth symbol, go to SOLVE.
- SOLVE: exactly one cycle, in_ready = 0. Uses log/antilog tables generated at elaboration from PRIM_POLY (Q = 2^m-1):
  - S1 = 0 and S2 = 0: no error.
  - Exactly one of S1, S2 = 0: uncorrectable.
  - Both nonzero: j = (log S2 - log S1) mod Q.
    - j >= N: uncorrectable.
    - Otherwise Y1 = antilog((2·log S1 - log S2) mod Q); corrected, err_loc = j.
  - Flags are registered at the SOLVE -> OUTPUT edge.
- OUTPUT: in_ready = 0, out_valid = 1.
  - out_symbol = buf[k] ^ (Y1 if corrected and degree(k) = j, else 0), where degree(k) = N-1-k.
  - k advances only on out_valid && out_ready; out_symbol is stable while stalled.
  - out_last = 1 when k = N-1. Its handshake clears out_valid and all err_* (err_loc -> 0), zeroes S1/S2/cnt, and returns to COLLECT.
- Latency: the first output symbol is valid 2 cycles after the cycle in which the Nth input is accepted. Throughput is 2N+1 cycles per codeword with no stalls. There is no input/output overlap: in_ready stays 0 from SOLVE through the final output handshake.
- Flags err_detected, err_corrected, err_uncorrectable and err_loc are constant for all N output beats. err_corrected and err_uncorrectable are never both 1.
- Backpressure: out_ready may toggle arbitrarily; no symbol is dropped or duplicated. in_valid gaps simply pause COLLECT.
- Reset asserted mid-COLLECT or mid-OUTPUT aborts the current codeword immediately (asynchronous). Partial data is discarded. After release, the first accepted symbol is treated as degree N-1.
- GF multiply by α / α² is shift-and-reduce by PRIM_POLY; GF add is XOR.

Test Plan (defaults: m=3, N=7, x³+x+1; α¹..α⁶ = 2,4,3,6,7,5; symbols listed degree 6 → 0):
- Clean codeword 0,0,0,0,0,0,0 -> output identical; err_detected = 0, err_corrected = 0, err_uncorrectable = 0; first out_valid 2 cycles after the 7th input.
- Single error 0,0,0,0,5,0,0 -> S1 = 2, S2 = 3, X1 = 4 (j = 2), Y1 = 5; output all zeros; err_detected = 1, err_corrected = 1, err_loc = 2.
- Uncorrectable 0,0,0,0,0,1,2 -> S1 = 0, S2 = 6; output unchanged 0,0,0,0,0,1,2; err_uncorrectable = 1, err_corrected = 0.
- Backpressure on the single-error case: out_ready pattern 1,0,0,1,0,1,1,… -> same 7 output symbols in order, out_symbol stable during stalls, out_last on the 7th beat only, in_ready = 0 throughout OUTPUT.
- Reset pulse after 4 symbols accepted, then a clean 7-symbol codeword -> all outputs 0 during reset; the subsequent codeword decodes cleanly with no residue from the aborted one.
- Back-to-back codewords (error at degree 6 with value 1, then degree 0 with value 7) -> err_loc = 6 then err_loc = 0; flags update only at codeword boundaries.

Source files
------------

// File: rtl/rs_stream_decoder_if.sv
// Stream bus of the RS decoder: symbol input, corrected symbol output and
// per-codeword status flags.
interface rs_stream_decoder_if #(
  parameter int SYMBOL_WIDTH = 3,
  parameter int LOC_WIDTH    = 3
);
  // A beat transfers on the rising clock edge where valid && ready are both 1;
  // the producer holds data stable while valid is high and ready is low.
  logic                    in_valid;
  logic                    in_ready;
  logic [SYMBOL_WIDTH-1:0] in_symbol;
  logic                    out_valid;
  logic                    out_ready;
  logic [SYMBOL_WIDTH-1:0] out_symbol;
  logic                    out_last;
  logic                    err_detected;
  logic                    err_corrected;
  logic                    err_uncorrectable;
  logic [LOC_WIDTH-1:0]    err_loc;

  modport master (
    output in_valid, in_symbol, out_ready,
    input  in_ready, out_valid, out_symbol, out_last,
           err_detected, err_corrected, err_uncorrectable, err_loc
  );

  modport slave (
    input  in_valid, in_symbol, out_ready,
    output in_ready, out_valid, out_symbol, out_last,
           err_detected, err_corrected, err_uncorrectable, err_loc
  );
endinterface

// File: rtl/rs_stream_decoder.sv
// Streaming single-symbol-error Reed-Solomon decoder over GF(2^m): collects a
// codeword while building S1/S2, solves in one cycle, streams out the fix.
module rs_stream_decoder #(
  parameter int                    SYMBOL_WIDTH = 3,
  parameter int                    N            = 7,
  parameter logic [SYMBOL_WIDTH:0] PRIM_POLY    = 4'b1011,
  parameter int                    LOC_WIDTH    = $clog2(N)
) (
  input  logic       clk,
  input  logic       reset,
  rs_stream_decoder_if.slave bus,
  output logic [1:0] state_dbg
);

  localparam int Q  = (1 << SYMBOL_WIDTH) - 1;
  localparam int TW = SYMBOL_WIDTH * (Q + 1);
  localparam logic [LOC_WIDTH-1:0] LAST_IDX = LOC_WIDTH'(N - 1);

  typedef logic [SYMBOL_WIDTH-1:0] sym_t;
  typedef enum logic [1:0] {COLLECT = 2'd0, SOLVE = 2'd1, OUTPUT = 2'd2} state_t;

  function automatic sym_t mul_alpha(input sym_t x);
    logic [SYMBOL_WIDTH:0] t;
    t = {x, 1'b0};
    if (t[SYMBOL_WIDTH]) t = t ^ PRIM_POLY;
    return t[SYMBOL_WIDTH-1:0];
  endfunction

  // Antilog table: entry i holds alpha^i for i in 0..Q-1.
  function automatic logic [TW-1:0] build_exp();
    logic [TW-1:0] t;
    sym_t          a;
    t = '0;
    a = sym_t'(1);
    for (int i = 0; i < Q; i++) begin
      t[i*SYMBOL_WIDTH +: SYMBOL_WIDTH] = a;
      a = mul_alpha(a);
    end
    return t;
  endfunction

  // Log table indexed by field element; entry 0 is unused.
  function automatic logic [TW-1:0] build_log();
    logic [TW-1:0] t;
    sym_t          a;
    t = '0;
    a = sym_t'(1);
    for (int i = 0; i < Q; i++) begin
      t[int'(a)*SYMBOL_WIDTH +: SYMBOL_WIDTH] = SYMBOL_WIDTH'(i);
      a = mul_alpha(a);
    end
    return t;
  endfunction

  localparam logic [TW-1:0] EXP_TBL = build_exp();
  localparam logic [TW-1:0] LOG_TBL = build_log();

  state_t               state, state_next;
  logic [LOC_WIDTH-1:0] cnt;
  sym_t                 s1, s2;
  sym_t                 y1;
  logic [LOC_WIDTH-1:0] fix_idx;
  logic                 det_q, corr_q, unc_q;
  logic [LOC_WIDTH-1:0] loc_q;
  sym_t                 sym_buf [N];

  logic                 accept, out_fire, last_in, last_out;

  int                   l1, l2, dj, de;
  logic                 sol_det, sol_corr, sol_unc;
  sym_t                 y_calc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= COLLECT;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      COLLECT: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && cnt == LAST_IDX) state_next = SOLVE;
      end
      SOLVE: state_next = OUTPUT;
      OUTPUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready && cnt == LAST_IDX) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  assign accept   = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;
  assign last_in  = accept && (cnt == LAST_IDX);
  assign last_out = out_fire && (cnt == LAST_IDX);

  // Error position is log(S2/S1); error value is S1^2/S2, both mod Q.
  always_comb begin
    l1 = int'(LOG_TBL[int'(s1)*SYMBOL_WIDTH +: SYMBOL_WIDTH]);
    l2 = int'(LOG_TBL[int'(s2)*SYMBOL_WIDTH +: SYMBOL_WIDTH]);
    dj = l2 - l1;
    if (dj < 0) dj = dj + Q;
    de = 2 * l1 - l2;
    if (de < 0)       de = de + Q;
    else if (de >= Q) de = de - Q;
    y_calc   = EXP_TBL[de*SYMBOL_WIDTH +: SYMBOL_WIDTH];
    sol_det  = (s1 != '0) || (s2 != '0);
    sol_corr = (s1 != '0) && (s2 != '0) && (dj < N);
    sol_unc  = sol_det && !sol_corr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      s1      <= '0;
      s2      <= '0;
      y1      <= '0;
      fix_idx <= '0;
      det_q   <= 1'b0;
      corr_q  <= 1'b0;
      unc_q   <= 1'b0;
      loc_q   <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            s1  <= mul_alpha(s1) ^ bus.in_symbol;
            s2  <= mul_alpha(mul_alpha(s2)) ^ bus.in_symbol;
            cnt <= last_in ? '0 : cnt + 1'b1;
          end
        end
        SOLVE: begin
          det_q   <= sol_det;
          corr_q  <= sol_corr;
          unc_q   <= sol_unc;
          loc_q   <= sol_corr ? LOC_WIDTH'(dj) : '0;
          fix_idx <= sol_corr ? LAST_IDX - LOC_WIDTH'(dj) : '0;
          y1      <= sol_corr ? y_calc : '0;
        end
        OUTPUT: begin
          if (last_out) begin
            cnt    <= '0;
            s1     <= '0;
            s2     <= '0;
            det_q  <= 1'b0;
            corr_q <= 1'b0;
            unc_q  <= 1'b0;
            loc_q  <= '0;
          end else if (out_fire) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Buffer contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (accept) sym_buf[cnt] <= bus.in_symbol;
  end

  always_comb begin
    bus.out_symbol = '0;
    if (state == OUTPUT)
      bus.out_symbol = sym_buf[cnt] ^ ((corr_q && cnt == fix_idx) ? y1 : '0);
  end

  assign bus.out_last          = (state == OUTPUT) && (cnt == LAST_IDX);
  assign bus.err_detected      = det_q;
  assign bus.err_corrected     = corr_q;
  assign bus.err_uncorrectable = unc_q;
  assign bus.err_loc           = loc_q;
  assign state_dbg             = state;

endmodule

// File: tb/tb_rs_stream_decoder.sv
// Bench for rs_stream_decoder: codeword driver, ready driver, and a monitor
// checking every output beat against a brute-force single-error model.
module tb_rs_stream_decoder;
  localparam int SW = 3;
  localparam int N  = 7;
  localparam int LW = 3;
  localparam logic [SW:0] PRIM = 4'b1011;
  localparam int EW = SW + 4 + LW;

  typedef logic [N*SW-1:0] cw_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] state_dbg;

  rs_stream_decoder_if #(.SYMBOL_WIDTH(SW), .LOC_WIDTH(LW)) bus ();

  rs_stream_decoder #(.SYMBOL_WIDTH(SW), .N(N), .PRIM_POLY(PRIM)) dut (
    .clk(clk), .reset(reset), .bus(bus), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- GF(8) reference arithmetic ----------------
  function automatic logic [SW-1:0] gmul(input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic [SW-1:0] r, aa;
    logic [SW:0]   t;
    r  = '0;
    aa = a;
    for (int i = 0; i < SW; i++) begin
      if (b[i]) r = r ^ aa;
      t = {aa, 1'b0};
      if (t[SW]) t = t ^ PRIM;
      aa = t[SW-1:0];
    end
    return r;
  endfunction

  function automatic logic [SW-1:0] gpow(input logic [SW-1:0] x, input int e);
    logic [SW-1:0] r;
    r = SW'(1);
    for (int i = 0; i < e; i++) r = gmul(r, x);
    return r;
  endfunction

  function automatic logic [SW-1:0] eval_at(input cw_t cw, input logic [SW-1:0] x);
    logic [SW-1:0] r;
    r = '0;
    for (int d = 0; d < N; d++) r = r ^ gmul(cw[d*SW +: SW], gpow(x, d));
    return r;
  endfunction

  // Valid codeword: random data in degrees N-1..2, parity found by search.
  function automatic cw_t make_codeword();
    cw_t cw;
    cw = '0;
    for (int d = 2; d < N; d++) cw[d*SW +: SW] = SW'($urandom_range(0, (1 << SW) - 1));
    for (int p = 0; p < (1 << (2*SW)); p++) begin
      cw[0 +: 2*SW] = (2*SW)'(p);
      if (eval_at(cw, SW'(2)) == '0 && eval_at(cw, SW'(4)) == '0) break;
    end
    return cw;
  endfunction

  // Model: try every single-error pattern y*x^j against the syndromes.
  task automatic expect_cw(input cw_t cw);
    logic [SW-1:0] s1, s2, y, sym;
    logic          det, corr, unc;
    int            loc;
    s1 = eval_at(cw, SW'(2));
    s2 = eval_at(cw, SW'(4));
    det = (s1 != 0) || (s2 != 0);
    corr = 1'b0;
    loc = 0;
    y = '0;
    if (det) begin
      for (int j = 0; j < N; j++)
        for (int v = 1; v < (1 << SW); v++)
          if (gmul(SW'(v), gpow(SW'(2), j)) == s1 && gmul(SW'(v), gpow(SW'(4), j)) == s2) begin
            corr = 1'b1;
            loc  = j;
            y    = SW'(v);
          end
    end
    unc = det && !corr;
    for (int d = N - 1; d >= 0; d--) begin
      sym = cw[d*SW +: SW] ^ ((corr && d == loc) ? y : '0);
      exp_q.push_back({sym, (d == 0), det, corr, unc, LW'(loc)});
    end
  endtask

  // ---------------- drivers ----------------
  int rdy_mode = 2;
  int pat_i = 0;
  bit pat_bits [7] = '{1, 0, 0, 1, 0, 1, 1};

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: begin
          bus.out_ready = pat_bits[pat_i % 7];
          pat_i++;
        end
        2:       bus.out_ready = 1'b1;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic send_sym(input logic [SW-1:0] s);
    int guard;
    bus.in_valid  = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b1;
    bus.in_symbol = s;
    guard = 0;
    while (!bus.in_ready && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 500) check("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_cw(input cw_t cw);
    for (int d = N - 1; d >= 0; d--) send_sym(cw[d*SW +: SW]);
    expect_cw(cw);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- monitor ----------------
  logic          stalled = 1'b0;
  logic [SW:0]   held;
  logic [EW-1:0] got, e;

  always @(negedge clk) begin
    if (bus.out_valid) begin
      check("in_ready_low_in_output", 32'(bus.in_ready), 32'd0);
      check("flags_exclusive", 32'(bus.err_corrected & bus.err_uncorrectable), 32'd0);
      if (stalled) check("stall_stable", 32'({bus.out_last, bus.out_symbol}), 32'(held));
      got = {bus.out_symbol, bus.out_last, bus.err_detected, bus.err_corrected,
             bus.err_uncorrectable, bus.err_loc};
      if (bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(got), 32'h7fffffff);
        end else begin
          e = exp_q.pop_front();
          check("out_beat", 32'(got), 32'(e));
        end
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = {bus.out_last, bus.out_symbol};
      end
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_last"}, 32'(bus.out_last), 32'd0);
    check({tag, "_out_symbol"}, 32'(bus.out_symbol), 32'd0);
    check({tag, "_flags"}, 32'({bus.err_detected, bus.err_corrected, bus.err_uncorrectable}), 32'd0);
    check({tag, "_err_loc"}, 32'(bus.err_loc), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    cw_t cw;
    int  kind, p1, p2;
    bus.in_valid  = 1'b0;
    bus.in_symbol = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Clean all-zero codeword, plus first-output latency.
    rdy_mode = 2;
    send_cw('0);
    check("latency_solve_cycle_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("latency_first_valid", 32'(bus.out_valid), 32'd1);
    wait_drain();

    // Single error at degree 2, value 5; then uncorrectable 0,0,0,0,0,1,2.
    rdy_mode = 0;
    send_cw(cw_t'(5) << (2*SW));
    wait_drain();
    send_cw((cw_t'(1) << SW) | cw_t'(2));
    wait_drain();

    // Fixed backpressure pattern on the single-error codeword.
    pat_i = 0;
    rdy_mode = 1;
    send_cw(cw_t'(5) << (2*SW));
    wait_drain();

    // Reset pulse after four accepted symbols, then a fresh valid codeword.
    rdy_mode = 0;
    for (int d = N - 1; d > N - 5; d--) send_sym(SW'($urandom_range(1, 7)));
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(posedge clk);
    #1;
    reset = 1'b1;
    send_cw(make_codeword());
    wait_drain();

    // Back-to-back: degree 6 value 1, then degree 0 value 7.
    send_cw(cw_t'(1) << (6*SW));
    send_cw(cw_t'(7));
    wait_drain();

    // Randomized codewords: clean, single, double and arbitrary errors.
    for (int n = 0; n < 16; n++) begin
      rdy_mode = (n % 3 == 0) ? 2 : 0;
      cw   = make_codeword();
      kind = $urandom_range(0, 3);
      p1   = $urandom_range(0, N - 1);
      p2   = (p1 + $urandom_range(1, N - 1)) % N;
      case (kind)
        1: cw[p1*SW +: SW] = cw[p1*SW +: SW] ^ SW'($urandom_range(1, 7));
        2: begin
          cw[p1*SW +: SW] = cw[p1*SW +: SW] ^ SW'($urandom_range(1, 7));
          cw[p2*SW +: SW] = cw[p2*SW +: SW] ^ SW'($urandom_range(1, 7));
        end
        3: for (int d = 0; d < N; d++) cw[d*SW +: SW] = SW'($urandom_range(0, 7));
        default: ;
      endcase
      send_cw(cw);
    end
    wait_drain();
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
